// File: rtl/decode_pkg.sv
// Shared opcode constants, ALU operation codes and the decoded control bundle
// used by the decode stage and its combinational decoder.
package decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLTU  = 4'd5,
        ALU_SLT   = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    reg_write;
        logic    alu_src;
        logic    pc_src;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    branch;
        logic    jump;
        logic    jump_reg;
        logic    illegal;
    } ctrl_t;

    // funct3 to ALU op; alt selects SUB/SRA on the two funct3 codes that have a variant
    function automatic alu_op_e alu_op_from_funct(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_pipe_stage_comb.sv
// Purely combinational RV32I/RV32E instruction decoder: raw instruction in,
// control bundle, register addresses and operand-usage flags out.
module decode_comb
    import decode_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [31:0]           instr,
    output ctrl_t                 ctrl,
    output logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  uses_rs1,
    output logic                  uses_rs2
);

    localparam bit IS_RV32E = (REG_ADDR_W == 4);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       uses_rd;
    logic       bad;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rs1_addr = instr[15 +: REG_ADDR_W];
    assign rs2_addr = instr[20 +: REG_ADDR_W];
    assign rd_addr  = instr[7 +: REG_ADDR_W];

    // Operand usage follows the opcode alone so the hazard check stays cheap
    always_comb begin
        uses_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
        uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    end

    // Opcode decode, legality checks, then squash of side-effecting controls
    always_comb begin
        ctrl    = '0;
        uses_rd = 1'b0;
        bad     = 1'b0;
        case (opcode)
            OPC_OP: begin
                ctrl.alu_op    = alu_op_from_funct(funct3, funct7 == FUNCT7_ALT);
                ctrl.reg_write = 1'b1;
                uses_rd        = 1'b1;
                if (funct3 == 3'b000 || funct3 == 3'b101)
                    bad = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
                else
                    bad = (funct7 != FUNCT7_BASE);
            end
            OPC_OP_IMM: begin
                // funct3 000 is always ADDI: bits 31:25 are immediate there
                ctrl.alu_op    = alu_op_from_funct(funct3,
                                     (funct3 == 3'b101) && (funct7 == FUNCT7_ALT));
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                uses_rd        = 1'b1;
                if (funct3 == 3'b001)
                    bad = (funct7 != FUNCT7_BASE);
                else if (funct3 == 3'b101)
                    bad = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
            end
            OPC_LOAD: begin
                ctrl.alu_op     = ALU_ADD;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                uses_rd         = 1'b1;
                bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                bad = (funct3 > 3'b010);
            end
            OPC_BRANCH: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.branch = 1'b1;
                bad = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_JAL: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.pc_src    = 1'b1;
                ctrl.alu_src   = 1'b1;
                uses_rd        = 1'b1;
            end
            OPC_JALR: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.jump_reg  = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                uses_rd        = 1'b1;
                bad = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                ctrl.alu_op    = ALU_PASSB;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                uses_rd        = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                uses_rd        = 1'b1;
            end
            default: bad = 1'b1;
        endcase

        if (instr[1:0] != 2'b11)
            bad = 1'b1;
        // RV32E only has x0..x15; bit 4 of any used field set means out of range
        if (IS_RV32E && ((uses_rs1 && instr[19]) || (uses_rs2 && instr[24]) ||
                         (uses_rd && instr[11])))
            bad = 1'b1;

        if (bad) begin
            ctrl.illegal    = 1'b1;
            ctrl.reg_write  = 1'b0;
            ctrl.mem_read   = 1'b0;
            ctrl.mem_write  = 1'b0;
            ctrl.mem_to_reg = 1'b0;
            ctrl.branch     = 1'b0;
            ctrl.jump       = 1'b0;
            ctrl.jump_reg   = 1'b0;
        end
    end

endmodule

// File: rtl/decode_pipe_stage.sv
// Registered decode stage: valid/ready pipeline register around decode_comb,
// load-use bubble insertion, flush and a saturating bubble counter.
module decode_pipe_stage
    import decode_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter bit HAZARD_EN   = 1'b1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [REG_ADDR_W-1:0]  out_rs1_addr,
    output logic [REG_ADDR_W-1:0]  out_rs2_addr,
    output logic [REG_ADDR_W-1:0]  out_rd_addr,
    output logic [3:0]             out_alu_op,
    output logic                   out_reg_write,
    output logic                   out_alu_src,
    output logic                   out_pc_src,
    output logic                   out_mem_read,
    output logic                   out_mem_write,
    output logic                   out_mem_to_reg,
    output logic                   out_branch,
    output logic                   out_jump,
    output logic                   out_jump_reg,
    output logic                   out_illegal,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    ctrl_t                  dec_ctrl;
    logic [REG_ADDR_W-1:0]  dec_rs1, dec_rs2, dec_rd;
    logic                   dec_uses_rs1, dec_uses_rs2;

    logic                   out_valid_q, out_valid_d;
    ctrl_t                  ctrl_q, ctrl_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic [REG_ADDR_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic                   hazard;

    decode_comb #(.REG_ADDR_W(REG_ADDR_W)) u_decode_comb (
        .instr    (in_instr),
        .ctrl     (dec_ctrl),
        .rs1_addr (dec_rs1),
        .rs2_addr (dec_rs2),
        .rd_addr  (dec_rd),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2)
    );

    // Load-use hazard: the held load writes a register the incoming instruction reads
    always_comb begin
        hazard = HAZARD_EN && out_valid_q && ctrl_q.mem_read && (rd_q != '0) && in_valid &&
                 ((dec_uses_rs1 && (dec_rs1 == rd_q)) || (dec_uses_rs2 && (dec_rs2 == rd_q)));
        in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    end

    // Next-state for the pipeline register and bubble counter
    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        pc_d        = pc_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec_ctrl;
            pc_d        = in_pc;
            rs1_d       = dec_rs1;
            rs2_d       = dec_rs2;
            rd_d        = dec_rd;
        end else if (out_ready) begin
            // Held bundle drained (or nothing held); a hazard here is a real bubble
            out_valid_d = 1'b0;
            if (hazard && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // Pipeline register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            pc_q        <= pc_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pc         = pc_q;
    assign out_rs1_addr   = rs1_q;
    assign out_rs2_addr   = rs2_q;
    assign out_rd_addr    = rd_q;
    assign out_alu_op     = ctrl_q.alu_op;
    assign out_reg_write  = ctrl_q.reg_write;
    assign out_alu_src    = ctrl_q.alu_src;
    assign out_pc_src     = ctrl_q.pc_src;
    assign out_mem_read   = ctrl_q.mem_read;
    assign out_mem_write  = ctrl_q.mem_write;
    assign out_mem_to_reg = ctrl_q.mem_to_reg;
    assign out_branch     = ctrl_q.branch;
    assign out_jump       = ctrl_q.jump;
    assign out_jump_reg   = ctrl_q.jump_reg;
    assign out_illegal    = ctrl_q.illegal;
    assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage: a default instance plus a no-hazard
// instance and an RV32E instance, all driven from the same stimulus.
module tb_decode_pipe_stage;

    logic        clk, rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        in_ready, out_valid, out_reg_write, out_alu_src, out_pc_src, out_mem_read;
    logic        out_mem_write, out_mem_to_reg, out_branch, out_jump, out_jump_reg, out_illegal;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr;
    logic [3:0]  out_alu_op;
    logic [15:0] stall_cnt;

    logic        h0_in_ready, h0_out_valid, h0_reg_write, h0_alu_src, h0_pc_src, h0_mem_read;
    logic        h0_mem_write, h0_mem_to_reg, h0_branch, h0_jump, h0_jump_reg, h0_illegal;
    logic [31:0] h0_pc;
    logic [4:0]  h0_rs1, h0_rs2, h0_rd;
    logic [3:0]  h0_alu_op;
    logic [15:0] h0_stall_cnt;

    logic        e_in_ready, e_out_valid, e_reg_write, e_alu_src, e_pc_src, e_mem_read;
    logic        e_mem_write, e_mem_to_reg, e_branch, e_jump, e_jump_reg, e_illegal;
    logic [31:0] e_pc;
    logic [3:0]  e_rs1, e_rs2, e_rd;
    logic [3:0]  e_alu_op;
    logic [15:0] e_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    decode_pipe_stage #(.PC_W(32), .REG_ADDR_W(5), .HAZARD_EN(1'b1), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
        .out_rd_addr(out_rd_addr), .out_alu_op(out_alu_op), .out_reg_write(out_reg_write),
        .out_alu_src(out_alu_src), .out_pc_src(out_pc_src), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg), .out_branch(out_branch),
        .out_jump(out_jump), .out_jump_reg(out_jump_reg), .out_illegal(out_illegal),
        .stall_cnt(stall_cnt)
    );

    decode_pipe_stage #(.PC_W(32), .REG_ADDR_W(5), .HAZARD_EN(1'b0), .STALL_CNT_W(16)) dut_h0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(h0_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(h0_out_valid), .out_ready(out_ready),
        .out_pc(h0_pc), .out_rs1_addr(h0_rs1), .out_rs2_addr(h0_rs2),
        .out_rd_addr(h0_rd), .out_alu_op(h0_alu_op), .out_reg_write(h0_reg_write),
        .out_alu_src(h0_alu_src), .out_pc_src(h0_pc_src), .out_mem_read(h0_mem_read),
        .out_mem_write(h0_mem_write), .out_mem_to_reg(h0_mem_to_reg), .out_branch(h0_branch),
        .out_jump(h0_jump), .out_jump_reg(h0_jump_reg), .out_illegal(h0_illegal),
        .stall_cnt(h0_stall_cnt)
    );

    decode_pipe_stage #(.PC_W(32), .REG_ADDR_W(4), .HAZARD_EN(1'b1), .STALL_CNT_W(16)) dut_e (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(e_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(e_out_valid), .out_ready(out_ready),
        .out_pc(e_pc), .out_rs1_addr(e_rs1), .out_rs2_addr(e_rs2),
        .out_rd_addr(e_rd), .out_alu_op(e_alu_op), .out_reg_write(e_reg_write),
        .out_alu_src(e_alu_src), .out_pc_src(e_pc_src), .out_mem_read(e_mem_read),
        .out_mem_write(e_mem_write), .out_mem_to_reg(e_mem_to_reg), .out_branch(e_branch),
        .out_jump(e_jump), .out_jump_reg(e_jump_reg), .out_illegal(e_illegal),
        .stall_cnt(e_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        #2;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
        n_checks++; if ({out_reg_write, out_illegal, out_alu_op, out_pc} !== '0) begin n_fail++; $display("FAIL reset_bundle: got %0h want 0", {out_reg_write, out_illegal, out_alu_op, out_pc}); end
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_add_sub();
        do_reset();
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h100;
        tick();
        n_checks++; if ({out_valid, out_alu_op, out_reg_write, out_rd_addr} !== {1'b1, 4'd0, 1'b1, 5'd3}) begin n_fail++; $display("FAIL add_bundle: got v=%0b op=%0d rw=%0b rd=%0d want 1 0 1 3", out_valid, out_alu_op, out_reg_write, out_rd_addr); end
        n_checks++; if ({out_rs1_addr, out_rs2_addr, out_pc} !== {5'd1, 5'd2, 32'h100}) begin n_fail++; $display("FAIL add_regs: got rs1=%0d rs2=%0d pc=%0h want 1 2 100", out_rs1_addr, out_rs2_addr, out_pc); end
        in_instr = 32'h402081B3; in_pc = 32'h104;
        tick();
        n_checks++; if ({out_valid, out_alu_op, out_reg_write, out_rd_addr, out_pc} !== {1'b1, 4'd1, 1'b1, 5'd3, 32'h104}) begin n_fail++; $display("FAIL sub_bundle: got v=%0b op=%0d rw=%0b rd=%0d pc=%0h want 1 1 1 3 104", out_valid, out_alu_op, out_reg_write, out_rd_addr, out_pc); end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sub_drain: got %0b want 0", out_valid); end
    endtask

    task automatic test_load_use();
        do_reset();
        in_valid = 1'b1; in_instr = 32'h0000A283; in_pc = 32'h200;
        tick();
        n_checks++; if ({out_valid, out_mem_read, out_mem_to_reg, out_alu_src, out_rd_addr} !== {1'b1, 1'b1, 1'b1, 1'b1, 5'd5}) begin n_fail++; $display("FAIL lw_bundle: got v=%0b mr=%0b m2r=%0b src=%0b rd=%0d want 1 1 1 1 5", out_valid, out_mem_read, out_mem_to_reg, out_alu_src, out_rd_addr); end
        in_instr = 32'h00028333; in_pc = 32'h204;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hazard_in_ready: got %0b want 0", in_ready); end
        n_checks++; if (h0_in_ready !== 1'b1) begin n_fail++; $display("FAIL nohaz_in_ready: got %0b want 1", h0_in_ready); end
        tick();
        n_checks++; if ({out_valid, stall_cnt} !== {1'b0, 16'd1}) begin n_fail++; $display("FAIL bubble: got v=%0b stall=%0d want 0 1", out_valid, stall_cnt); end
        n_checks++; if ({h0_out_valid, h0_rd, h0_stall_cnt} !== {1'b1, 5'd6, 16'd0}) begin n_fail++; $display("FAIL nohaz_add: got v=%0b rd=%0d stall=%0d want 1 6 0", h0_out_valid, h0_rd, h0_stall_cnt); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL after_bubble_ready: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if ({out_valid, out_rd_addr, out_rs1_addr, out_pc, stall_cnt} !== {1'b1, 5'd6, 5'd5, 32'h204, 16'd1}) begin n_fail++; $display("FAIL add_after_lw: got v=%0b rd=%0d rs1=%0d pc=%0h stall=%0d want 1 6 5 204 1", out_valid, out_rd_addr, out_rs1_addr, out_pc, stall_cnt); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if ({out_valid, stall_cnt, out_reg_write} !== {1'b0, 16'd0, 1'b0}) begin n_fail++; $display("FAIL mid_reset: got v=%0b stall=%0d rw=%0b want 0 0 0", out_valid, stall_cnt, out_reg_write); end
        rst = 1'b0;
    endtask

    task automatic test_op_imm_shift();
        do_reset();
        in_valid = 1'b1; in_instr = 32'h4030D093;
        tick();
        n_checks++; if ({out_valid, out_alu_op, out_alu_src, out_reg_write, out_illegal} !== {1'b1, 4'd9, 1'b1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL srai: got v=%0b op=%0d src=%0b rw=%0b ill=%0b want 1 9 1 1 0", out_valid, out_alu_op, out_alu_src, out_reg_write, out_illegal); end
        in_instr = 32'h0030D093;
        tick();
        n_checks++; if ({out_alu_op, out_alu_src, out_illegal} !== {4'd8, 1'b1, 1'b0}) begin n_fail++; $display("FAIL srli: got op=%0d src=%0b ill=%0b want 8 1 0", out_alu_op, out_alu_src, out_illegal); end
        in_instr = 32'hFE30D093;
        tick();
        n_checks++; if ({out_valid, out_illegal, out_reg_write} !== {1'b1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL bad_shift: got v=%0b ill=%0b rw=%0b want 1 1 0", out_valid, out_illegal, out_reg_write); end
        in_instr = 32'hFE308093;
        tick();
        n_checks++; if ({out_alu_op, out_illegal, out_reg_write} !== {4'd0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL addi_neg: got op=%0d ill=%0b rw=%0b want 0 0 1", out_alu_op, out_illegal, out_reg_write); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        do_reset();
        in_valid = 1'b1; in_instr = 32'hFFFFFFFF;
        tick();
        n_checks++; if ({out_valid, out_illegal, out_reg_write, out_jump} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin n_fail++; $display("FAIL ones: got v=%0b ill=%0b rw=%0b j=%0b want 1 1 0 0", out_valid, out_illegal, out_reg_write, out_jump); end
        in_instr = 32'h00000000;
        tick();
        n_checks++; if ({out_valid, out_illegal, out_mem_read} !== {1'b1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL zeros: got v=%0b ill=%0b mr=%0b want 1 1 0", out_valid, out_illegal, out_mem_read); end
        in_instr = 32'h0000B283;
        tick();
        n_checks++; if ({out_illegal, out_mem_read, out_mem_to_reg} !== {1'b1, 1'b0, 1'b0}) begin n_fail++; $display("FAIL load_f3: got ill=%0b mr=%0b m2r=%0b want 1 0 0", out_illegal, out_mem_read, out_mem_to_reg); end
        in_instr = 32'h000090E7;
        tick();
        n_checks++; if ({out_illegal, out_jump_reg} !== {1'b1, 1'b0}) begin n_fail++; $display("FAIL jalr_f3: got ill=%0b jr=%0b want 1 0", out_illegal, out_jump_reg); end
        in_instr = 32'h002088B3;
        tick();
        n_checks++; if ({out_illegal, out_rd_addr} !== {1'b0, 5'd17}) begin n_fail++; $display("FAIL rv32i_x17: got ill=%0b rd=%0d want 0 17", out_illegal, out_rd_addr); end
        n_checks++; if ({e_out_valid, e_illegal, e_reg_write, e_rd} !== {1'b1, 1'b1, 1'b0, 4'd1}) begin n_fail++; $display("FAIL rv32e_x17: got v=%0b ill=%0b rw=%0b rd=%0d want 1 1 0 1", e_out_valid, e_illegal, e_reg_write, e_rd); end
        in_instr = 32'h002081B3;
        tick();
        n_checks++; if ({e_illegal, e_reg_write, e_rd} !== {1'b0, 1'b1, 4'd3}) begin n_fail++; $display("FAIL rv32e_x3: got ill=%0b rw=%0b rd=%0d want 0 1 3", e_illegal, e_reg_write, e_rd); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_pressure();
        int transfers;
        do_reset();
        transfers = 0;
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h10;
        tick();
        in_instr = 32'h402081B3; in_pc = 32'h14; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, in_ready); end
            tick();
            n_checks++; if ({out_valid, out_pc, out_alu_op} !== {1'b1, 32'h10, 4'd0}) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%0b pc=%0h op=%0d want 1 10 0", i, out_valid, out_pc, out_alu_op); end
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid === 1'b1 && out_pc === 32'h14) transfers++;
            tick();
        end
        n_checks++; if (transfers != 1) begin n_fail++; $display("FAIL bp_transfers: got %0d want 1", transfers); end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; in_instr = 32'h0000A283; in_pc = 32'h40;
        tick();
        in_instr = 32'h00028333; in_pc = 32'h44; flush = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %0b want 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if ({out_valid, stall_cnt} !== {1'b0, 16'd0}) begin n_fail++; $display("FAIL flush_kill: got v=%0b stall=%0d want 0 0", out_valid, stall_cnt); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_not_taken: got %0b want 0", out_valid); end
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h48; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_held: got %0b want 0", out_valid); end
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_load_use();
        test_op_imm_shift();
        test_illegal();
        test_back_pressure();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_pipe_stage.md
Name: decode_pipe_stage

Overview:
- Registered RV32I/RV32E decode stage between the IF/ID and ID/EX boundaries.
- Accepts instructions over a valid/ready handshake and fully decodes OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI and AUIPC, including OP_IMM ALU ops and shift variants.
- Flags illegal encodings and inserts a one-cycle bubble on load-use hazards.
- Honours a pipeline flush and counts stall cycles.

Parameters:
- PC_W, 32, width of the program counter carried with each instruction.
- REG_ADDR_W, 5, register address width; 4 selects RV32E, where addresses of 16 or more are illegal.
- HAZARD_EN, 1, enables load-use bubble insertion; 0 means in_ready follows the output handshake only.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  kill the held instruction and any incoming transfer this cycle.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage accepts an instruction this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_pc  out  PC_W  registered PC.
- out_rs1_addr, out_rs2_addr, out_rd_addr  out  REG_ADDR_W each  register addresses.
- out_alu_op  out  4  ALU operation code (package enum).
- out_reg_write, out_alu_src, out_pc_src, out_mem_read, out_mem_write, out_mem_to_reg, out_branch, out_jump, out_jump_reg  out  1 each  control bits. out_pc_src=1 selects PC as ALU operand A (AUIPC, JAL).
- out_illegal  out  1  illegal encoding.
- stall_cnt  out  STALL_CNT_W  bubbles inserted since reset; saturates.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset: all out_* = 0, out_valid = 0, stall_cnt = 0. The registered bundle is cleared.
- Latency: 1 cycle. An instruction accepted at edge N appears on out_* after edge N.
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - While out_valid & !out_ready, the output register holds stable.
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Hazard (HAZARD_EN=1): out_valid & out_mem_read & out_rd_addr != 0 & in_valid, and the incoming instruction reads rs1 == out_rd_addr or rs2 == out_rd_addr.
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used by OP, STORE and BRANCH.
  - On hazard with out_ready=1: the register loads a bubble (out_valid=0) and stall_cnt increments.
  - With out_ready=0 there is no increment; the instruction simply waits.
- Flush has priority over everything: next out_valid = 0, in_ready = 0, no counter change.
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLTU 5, SLT 6, SLL 7, SRL 8, SRA 9, PASSB 10.
- Per-opcode decode:
  - OP: funct3/funct7 as the codes above. SUB and SRA require funct7 = 0100000; all others require 0000000.
  - OP_IMM: the same mapping, with alu_src=1. There is no SUBI: funct3 000 is ADD regardless of bits 31:25. SLLI needs imm[11:5]=0000000; SRLI/SRAI need 0000000/0100000.
  - LOAD: ADD, alu_src, mem_read, mem_to_reg, reg_write.
  - STORE: ADD, alu_src, mem_write.
  - BRANCH: branch, alu_op SUB.
  - JAL: jump, reg_write, pc_src, alu_src, ADD.
  - JALR: jump_reg, reg_write, alu_src, ADD.
  - LUI: PASSB, alu_src, reg_write.
  - AUIPC: ADD, pc_src, alu_src, reg_write.
- Illegal cases:
  - instr[1:0] != 11.
  - Unknown opcode.
  - Bad funct7 per the rules above.
  - LOAD funct3 in {011, 110, 111}.
  - STORE funct3 > 010.
  - BRANCH funct3 in {010, 011}.
  - JALR funct3 != 000.
  - RV32E with any used register field >= 16.
- Illegal bundle: out_valid=1, out_illegal=1, and all write/memory/branch/jump controls forced to 0.
- rd_addr = 0 with reg_write remains legal (NOP). Address fields always pass through truncated to REG_ADDR_W.
- stall_cnt saturates at all-ones.

Decomposition:
- Package decode_pkg: opcode constants, ALU op enum, and the control-bundle struct.
- One sub-module, decode_comb: the purely combinational instruction-to-bundle/illegal logic.
- The parent holds the pipeline register, handshake, hazard, flush and counter.

Test Plan:
- add x3,x1,x2 (0x002081B3) followed by sub (0x402081B3), out_ready=1 → consecutive cycles show alu_op 0 then 1, reg_write=1, rd=3.
- lw x5,0(x1) (0x0000A283) then add x6,x5,x0 (0x00028333) → one bubble cycle, in_ready=0 for 1 cycle, stall_cnt=1, add emerges a cycle later. HAZARD_EN=0 → no bubble.
- srai x1,x1,3 (0x4030D093) → alu_op 9, alu_src=1. The same instruction with bit30 cleared → alu_op 8. Bits 31:25 = 1111111 → out_illegal=1, reg_write=0.
- 0xFFFFFFFF and 0x00000000 → out_illegal=1. With REG_ADDR_W=4, add x17,x1,x2 → illegal.
- Hold out_ready=0 for 3 cycles → out_* stable, in_ready=0; release → one transfer, no loss or duplication.
- Assert flush with out_valid=1 and in_valid=1 → next cycle out_valid=0, the instruction is not accepted. rst asserted mid-stream → immediate out_valid=0, stall_cnt=0.
